// File: rtl/key_pkg.sv
// Shared definitions for the pushbutton debounce path and its consumers.
package key_pkg;

  localparam int unsigned NUM_KEYS = 4;

  localparam int unsigned KEY_DRUM  = 0;
  localparam int unsigned KEY_SYNTH = 1;
  localparam int unsigned KEY_MODE  = 2;
  localparam int unsigned KEY_DEMO  = 3;

  typedef enum logic [1:0] {
    ST_UP     = 2'd0,
    ST_CHK_DN = 2'd1,
    ST_DN     = 2'd2,
    ST_CHK_UP = 2'd3
  } key_state_e;

endpackage

// File: rtl/key_event_gen_if.sv
// KEY bus: raw buttons in, debounced levels and press/release pulses out.
interface key_event_gen_if;
  import key_pkg::*;

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;

  modport master (
    input  key_raw,
    output key_level,
    output key_press,
    output key_release
  );

  modport slave (
    output key_raw,
    input  key_level,
    input  key_press,
    input  key_release
  );
endinterface

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM and counter, registered outputs.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  key_state_e       r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic             r_level, w_level_n;
  logic             r_press, w_press_n;
  logic             r_release, w_release_n;
  logic             w_s;
  logic             w_cnt_done;

  assign w_s        = r_sync[1];
  assign w_cnt_done = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= '1;
      r_state   <= ST_UP;
      r_cnt     <= '0;
      r_level   <= 1'b1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_raw};
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_level   <= w_level_n;
      r_press   <= w_press_n;
      r_release <= w_release_n;
    end
  end

  // Counter is only advanced below CNT_LAST, so it saturates there instead of wrapping.
  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_level_n   = r_level;
    w_press_n   = 1'b0;
    w_release_n = 1'b0;
    case (r_state)
      ST_UP: begin
        if (!w_s) begin
          w_state_n = ST_CHK_DN;
          w_cnt_n   = '0;
        end
      end
      ST_CHK_DN: begin
        if (w_s) begin
          w_state_n = ST_UP;
          w_cnt_n   = '0;
        end else if (w_cnt_done) begin
          w_state_n = ST_DN;
          w_level_n = 1'b0;
          w_press_n = 1'b1;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      ST_DN: begin
        if (w_s) begin
          w_state_n = ST_CHK_UP;
          w_cnt_n   = '0;
        end
      end
      ST_CHK_UP: begin
        if (!w_s) begin
          w_state_n = ST_DN;
          w_cnt_n   = '0;
        end else if (w_cnt_done) begin
          w_state_n   = ST_UP;
          w_level_n   = 1'b1;
          w_release_n = 1'b1;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_n = ST_UP;
        w_cnt_n   = '0;
      end
    endcase
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/key_event_gen.sv
// Four independent debounced pushbutton channels driving the KEY bus.
module key_event_gen
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  key_event_gen_if.master  bus
);

  logic [NUM_KEYS-1:0] w_level;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_release;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_raw     (bus.key_raw[i]),
      .o_level   (w_level[i]),
      .o_press   (w_press[i]),
      .o_release (w_release[i])
    );
  end

  assign bus.key_level   = w_level;
  assign bus.key_press   = w_press;
  assign bus.key_release = w_release;

endmodule
